// File: rtl/norm_feeder_if.sv
// Row and norm-side bundle for norm_feeder.
// master is the feeder, slave is its environment (upstream + norm unit).
interface norm_feeder_if #(
  parameter int DWIDTH      = 8,
  parameter int DESIGN_SIZE = 32,
  parameter int MASK_WIDTH  = 32
);
  logic                          row_valid;
  logic [DESIGN_SIZE*DWIDTH-1:0] row_data;
  logic                          row_ready;
  logic                          enable_norm;
  logic [DWIDTH-1:0]             mean;
  logic [DWIDTH-1:0]             inv_var;
  logic [MASK_WIDTH-1:0]         validity_mask;
  logic                          in_data_available;
  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data;
  logic                          out_data_available;

  modport master (
    input  row_valid,
    input  row_data,
    input  out_data_available,
    output row_ready,
    output enable_norm,
    output mean,
    output inv_var,
    output validity_mask,
    output in_data_available,
    output inp_data
  );

  modport slave (
    output row_valid,
    output row_data,
    output out_data_available,
    input  row_ready,
    input  enable_norm,
    input  mean,
    input  inv_var,
    input  validity_mask,
    input  in_data_available,
    input  inp_data
  );
endinterface

// File: rtl/norm_feeder.sv
// Buffers upstream rows and feeds them to a norm unit,
// bounding rows in flight and tracking a job of num_rows rows.
module norm_feeder #(
  parameter int DWIDTH          = 8,
  parameter int DESIGN_SIZE     = 32,
  parameter int MASK_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            num_rows,
  input  logic [DWIDTH-1:0]     cfg_mean,
  input  logic [DWIDTH-1:0]     cfg_inv_var,
  input  logic [MASK_WIDTH-1:0] cfg_mask,
  norm_feeder_if.master         bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            issued_count,
  output logic [7:0]            returned_count
);

  localparam int RW = DESIGN_SIZE * DWIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [7:0]            num_rows_q;
  logic [7:0]            acc_q, acc_d;
  logic [7:0]            iss_q, iss_d;
  logic [7:0]            ret_q, ret_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DWIDTH-1:0]     mean_q;
  logic [DWIDTH-1:0]     inv_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [RW-1:0]         dat_q;
  logic                  ida_q;
  logic                  err_q;
  logic [RW-1:0]         mem [FIFO_DEPTH];

  logic       active, launch, rdy, push, pop;
  logic       ret_ok, ret_bad;
  logic [7:0] outst;

  assign active  = (state_q == RUN) || (state_q == DRAIN);
  assign launch  = (state_q == IDLE) && start;
  assign outst   = iss_q - ret_q;
  assign rdy     = (state_q == RUN) && (occ_q != OW'(FIFO_DEPTH))
                   && (acc_q < num_rows_q);
  assign push    = bus.row_valid && rdy;
  // Registered occupancy: a row written this cycle cannot pop until next.
  assign pop     = active && (occ_q != '0)
                   && (outst < 8'(MAX_OUTSTANDING));
  assign ret_ok  = bus.out_data_available && (state_q != IDLE)
                   && (outst != 8'd0);
  assign ret_bad = bus.out_data_available && !ret_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_rows == 8'd0) ? DONE : RUN;
      RUN:     if (acc_q == num_rows_q) state_d = DRAIN;
      DRAIN:   if (ret_q == num_rows_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    iss_d = iss_q;
    ret_d = ret_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (launch) begin
      acc_d = '0;
      iss_d = '0;
      ret_d = '0;
      wr_d  = '0;
      rd_d  = '0;
      occ_d = '0;
    end else begin
      if (push) begin
        acc_d = acc_q + 8'd1;
        wr_d  = wr_q + PW'(1);
      end
      if (pop) begin
        iss_d = iss_q + 8'd1;
        rd_d  = rd_q + PW'(1);
      end
      if (ret_ok) ret_d = ret_q + 8'd1;
      occ_d = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_rows_q <= '0;
      acc_q      <= '0;
      iss_q      <= '0;
      ret_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      mean_q     <= '0;
      inv_q      <= '0;
      mask_q     <= '0;
      dat_q      <= '0;
      ida_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      acc_q <= acc_d;
      iss_q <= iss_d;
      ret_q <= ret_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      ida_q <= pop;
      if (launch) begin
        num_rows_q <= num_rows;
        mean_q     <= cfg_mean;
        inv_q      <= cfg_inv_var;
        mask_q     <= cfg_mask;
      end
      if (pop)     dat_q <= mem[rd_q];
      if (ret_bad) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= bus.row_data;
  end

  assign bus.row_ready         = rdy;
  assign bus.enable_norm       = active;
  assign bus.mean              = mean_q;
  assign bus.inv_var           = inv_q;
  assign bus.validity_mask     = mask_q;
  assign bus.in_data_available = ida_q;
  assign bus.inp_data          = dat_q;
  assign busy                  = active;
  assign done                  = (state_q == DONE);
  assign err                   = err_q;
  assign issued_count          = iss_q;
  assign returned_count        = ret_q;

endmodule

// File: tb/tb_norm_feeder.sv
// Directed bench for norm_feeder: job table plus
// backpressure, protocol-error and mid-job reset sequences.
module tb_norm_feeder;

  localparam int RW = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_rows = '0;
  logic [7:0]  cfg_mean = '0;
  logic [7:0]  cfg_inv_var = '0;
  logic [31:0] cfg_mask = '0;
  logic        busy, done, err;
  logic [7:0]  issued_count, returned_count;

  norm_feeder_if bus ();

  norm_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_rows       (num_rows),
    .cfg_mean       (cfg_mean),
    .cfg_inv_var    (cfg_inv_var),
    .cfg_mask       (cfg_mask),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .issued_count   (issued_count),
    .returned_count (returned_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  cur_n, cur_mean, cur_inv, cur_base;
  logic [31:0] cur_mask;
  int sent, strobes, pending, cfg_bad;
  int done_cyc, acc_cyc, str_cyc;
  bit tb_acc, en_seen, done_seen;

  typedef struct {
    logic [7:0]  n;
    logic [7:0]  mean;
    logic [7:0]  inv;
    logic [31:0] mask;
    logic [7:0]  base;
    int          exp_cnt;
    bit          exp_en;
    int          exp_done_cyc;
  } vec_t;

  vec_t vt [6];

  function automatic logic [RW-1:0] mk_row(input logic [7:0] b, input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < 32; i++)
      v[i*8 +: 8] = b + 8'(r * 7) + 8'(i);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] n, input logic [7:0] m,
                           input logic [7:0] iv, input logic [31:0] mk,
                           input logic [7:0] b);
    @(negedge clk);
    cur_n = n; cur_mean = m; cur_inv = iv; cur_mask = mk; cur_base = b;
    sent = 0; strobes = 0; pending = 0; cfg_bad = 0;
    tb_acc = 0; en_seen = 0; done_seen = 0;
    done_cyc = -1; acc_cyc = -1; str_cyc = -1;
    start = 1'b1; num_rows = n;
    cfg_mean = m; cfg_inv_var = iv; cfg_mask = mk;
    bus.row_valid = 1'b0;
    bus.out_data_available = 1'b0;
  endtask

  task automatic run_cycles(input int ncyc, input bit ret_en,
                            input bit stop_done);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (tb_acc) sent++;
      bus.row_valid = (sent < int'(cur_n));
      bus.row_data  = mk_row(cur_base, sent);
      if (bus.in_data_available) begin
        chk($sformatf("row%0d", strobes), bus.inp_data,
            mk_row(cur_base, strobes));
        if (str_cyc < 0) str_cyc = c;
        strobes++;
        pending++;
      end
      if (bus.enable_norm) en_seen = 1'b1;
      if (busy && {bus.mean, bus.inv_var, bus.validity_mask} !==
                  {cur_mean, cur_inv, cur_mask}) cfg_bad++;
      bus.out_data_available = 1'b0;
      if (ret_en && pending > 0) begin
        bus.out_data_available = 1'b1;
        pending--;
      end
      tb_acc = bus.row_valid && bus.row_ready;
      if (tb_acc && acc_cyc < 0) acc_cyc = c;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = c;
        if (stop_done) break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, RW'({bus.row_ready, bus.enable_norm,
        bus.in_data_available, busy, done, err}), '0);
    chk({tag, "_cnt"}, RW'({issued_count, returned_count}), '0);
    chk({tag, "_cfg"}, RW'({bus.mean, bus.inv_var, bus.validity_mask}), '0);
    chk({tag, "_data"}, bus.inp_data, '0);
  endtask

  initial begin
    vt[0] = '{8'd1, 8'd30, 8'd2,  32'hFFFF_FFFF, 8'd20,  1, 1'b1, 4};
    vt[1] = '{8'd0, 8'd5,  8'd6,  32'h0000_FFFF, 8'd0,   0, 1'b0, 0};
    vt[2] = '{8'd3, 8'd11, 8'd12, 32'hA5A5_A5A5, 8'd40,  3, 1'b1, -1};
    vt[3] = '{8'd4, 8'd77, 8'd3,  32'h0F0F_0F0F, 8'd90,  4, 1'b1, -1};
    vt[4] = '{8'd6, 8'd1,  8'd99, 32'h8000_0001, 8'd200, 6, 1'b1, -1};
    vt[5] = '{8'd2, 8'd64, 8'd8,  32'h1234_5678, 8'd7,   2, 1'b1, -1};

    bus.row_valid = 1'b0;
    bus.row_data = '0;
    bus.out_data_available = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      start_job(vt[k].n, vt[k].mean, vt[k].inv, vt[k].mask, vt[k].base);
      run_cycles(200, 1'b1, 1'b1);
      chk($sformatf("v%0d_done", k), RW'(done_seen), RW'(1));
      chk($sformatf("v%0d_iss", k), RW'(issued_count), RW'(vt[k].exp_cnt));
      chk($sformatf("v%0d_ret", k), RW'(returned_count), RW'(vt[k].exp_cnt));
      chk($sformatf("v%0d_strb", k), RW'(strobes), RW'(vt[k].exp_cnt));
      chk($sformatf("v%0d_en", k), RW'(en_seen), RW'(vt[k].exp_en));
      chk($sformatf("v%0d_cfg", k), RW'(cfg_bad), RW'(0));
      chk($sformatf("v%0d_err", k), RW'(err), RW'(0));
      chk($sformatf("v%0d_mean", k), RW'(bus.mean), RW'(vt[k].mean));
      if (vt[k].exp_done_cyc >= 0)
        chk($sformatf("v%0d_dlat", k), RW'(done_cyc),
            RW'(vt[k].exp_done_cyc));
    end

    // Single row: accept-to-strobe latency and output values.
    start_job(8'd1, 8'd30, 8'd2, 32'hFFFF_FFFF, 8'd20);
    run_cycles(50, 1'b1, 1'b1);
    chk("lat_acc2strb", RW'(str_cyc - acc_cyc), RW'(2));
    chk("lat_byte0", RW'(mk_row(8'd20, 0) & RW'(8'hFF)), RW'(20));
    chk("lat_invvar", RW'(bus.inv_var), RW'(2));
    chk("lat_counts", RW'({issued_count, returned_count}), RW'(16'h0101));

    // Backpressure: norm never returns, FIFO fills.
    start_job(8'd8, 8'd3, 8'd4, 32'hFFFF_0000, 8'd100);
    run_cycles(20, 1'b0, 1'b0);
    chk("bp_strobes", RW'(strobes), RW'(2));
    chk("bp_issued", RW'(issued_count), RW'(2));
    chk("bp_accepted", RW'(sent), RW'(6));
    chk("bp_ready", RW'(bus.row_ready), RW'(0));
    chk("bp_busy", RW'(busy), RW'(1));
    run_cycles(200, 1'b1, 1'b1);
    chk("bp_done", RW'(done_seen), RW'(1));
    chk("bp_all", RW'({issued_count, returned_count}), RW'(16'h0808));
    chk("bp_strb_all", RW'(strobes), RW'(8));

    // Stray return in IDLE.
    @(negedge clk);
    bus.out_data_available = 1'b1;
    @(negedge clk);
    bus.out_data_available = 1'b0;
    chk("idle_err", RW'(err), RW'(1));
    chk("idle_cnt", RW'({issued_count, returned_count}), RW'(16'h0808));
    repeat (3) @(negedge clk);
    chk("err_sticky", RW'(err), RW'(1));
    #2 reset = 1'b0;
    #1 chk_zero("rst_err");
    @(negedge clk);
    reset = 1'b1;

    // Reset with rows in flight, then a fresh job.
    start_job(8'd8, 8'd9, 8'd9, 32'h0000_0001, 8'd50);
    run_cycles(12, 1'b0, 1'b0);
    chk("mid_issued", RW'(issued_count), RW'(2));
    #2 reset = 1'b0;
    bus.row_valid = 1'b0;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    start_job(8'd2, 8'd17, 8'd18, 32'hCAFE_F00D, 8'd60);
    run_cycles(100, 1'b1, 1'b1);
    chk("post_done", RW'(done_seen), RW'(1));
    chk("post_cnt", RW'({issued_count, returned_count}), RW'(16'h0202));
    chk("post_strb", RW'(strobes), RW'(2));
    chk("post_err", RW'(err), RW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
